// File: rtl/sysa_seq.sv
// Single-clock sequencer for the 3x3 systolic array: weight/row loading, flush, capture and result streaming.
// Define SYSA_SEQ_PERF_EN to build the perf_cycles job-cycle counter; otherwise perf_cycles is tied to 0.
module sysa_seq #(
  parameter int ARRAY_SIZE = 3,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [31:0]                           cfg_data,
  output logic                                  sa_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] sa_w,
  output logic [ARRAY_SIZE*DATA_W-1:0]          sa_in,
  input  logic [ACC_W-1:0]                      sa_out1,
  input  logic [ACC_W-1:0]                      sa_out2,
  input  logic [ACC_W-1:0]                      sa_out3,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [31:0]                           res_data,
  output logic [15:0]                           perf_cycles
);

  localparam int N         = ARRAY_SIZE;
  localparam int W_BITS    = N*N*DATA_W;
  localparam int WGT_WORDS = (W_BITS + 31) / 32;
  localparam int B_BITS    = N*N*ACC_W;
  localparam int RES_WORDS = (B_BITS + 31) / 32;
  localparam int STEPS     = 2*N - 1;
  localparam int K_W       = (WGT_WORDS > 1) ? $clog2(WGT_WORDS) : 1;
  localparam int R_W       = (N > 1) ? $clog2(N) : 1;
  localparam int S_W       = $clog2(STEPS + 1);
  localparam int J_W       = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t               state_reg;
  logic [K_W-1:0]       k_reg;
  logic [R_W-1:0]       r_reg;
  logic [S_W-1:0]       s_reg;
  logic [J_W-1:0]       j_reg;
  logic [W_BITS-1:0]    w_reg;
  logic [N*DATA_W-1:0]  sa_in_reg;
  logic                 sa_en_reg;
  logic                 done_reg;
  logic                 cap_v_reg;
  logic [S_W-1:0]       cap_s_reg;
  logic [B_BITS-1:0]    buf_reg;

  logic [ACC_W-1:0]     col_out [3];
  assign col_out[0] = sa_out1;
  assign col_out[1] = sa_out2;
  assign col_out[2] = sa_out3;

  // s_reg counts sa_en cycles already issued, so it equals the 1-based step
  // number during the sa_en cycle; capture happens one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      r_reg     <= '0;
      s_reg     <= '0;
      j_reg     <= '0;
      w_reg     <= '0;
      sa_in_reg <= '0;
      sa_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      cap_v_reg <= 1'b0;
      cap_s_reg <= '0;
      buf_reg   <= '0;
    end else begin
      done_reg  <= 1'b0;
      sa_en_reg <= 1'b0;
      sa_in_reg <= '0;
      cap_v_reg <= sa_en_reg;
      cap_s_reg <= s_reg;
      if (cap_v_reg) begin
        for (int c = 0; c < N; c++) begin
          if (int'(cap_s_reg) >= c + 1 && int'(cap_s_reg) <= c + N)
            buf_reg[(c*N + int'(cap_s_reg) - 1 - c)*ACC_W +: ACC_W] <= col_out[c];
        end
      end
      if (abort) begin
        state_reg <= S_IDLE;
        cap_v_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              state_reg <= S_LOAD_W;
              k_reg     <= '0;
              r_reg     <= '0;
              s_reg     <= '0;
              j_reg     <= '0;
              buf_reg   <= '0;
            end
          end
          S_LOAD_W: begin
            if (cfg_valid) begin
              // Bits of the last word beyond the weight vector are dropped.
              for (int b = 0; b < W_BITS; b++) begin
                if (b / 32 == int'(k_reg)) w_reg[b] <= cfg_data[b % 32];
              end
              if (k_reg == K_W'(WGT_WORDS - 1)) state_reg <= S_LOAD_X;
              else k_reg <= k_reg + 1'b1;
            end
          end
          S_LOAD_X: begin
            if (cfg_valid) begin
              sa_in_reg <= cfg_data[N*DATA_W-1:0];
              sa_en_reg <= 1'b1;
              s_reg     <= s_reg + 1'b1;
              if (r_reg == R_W'(N - 1)) state_reg <= S_RUN;
              else r_reg <= r_reg + 1'b1;
            end
          end
          S_RUN: begin
            sa_en_reg <= 1'b1;
            s_reg     <= s_reg + 1'b1;
            if (s_reg == S_W'(STEPS - 1)) state_reg <= S_DRAIN;
          end
          S_DRAIN: state_reg <= S_OUT;
          S_OUT: begin
            if (res_ready) begin
              if (j_reg == J_W'(RES_WORDS - 1)) begin
                state_reg <= S_IDLE;
                done_reg  <= 1'b1;
              end else begin
                j_reg <= j_reg + 1'b1;
              end
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  logic [RES_WORDS*32-1:0] buf_ext;
  logic [31:0]             res_word [RES_WORDS];
  assign buf_ext = {{(RES_WORDS*32 - B_BITS){1'b0}}, buf_reg};

  for (genvar gi = 0; gi < RES_WORDS; gi++) begin : g_res_word
    assign res_word[gi] = buf_ext[32*gi +: 32];
  end

  assign busy      = (state_reg != S_IDLE);
  assign cfg_ready = (state_reg == S_LOAD_W) || (state_reg == S_LOAD_X);
  assign res_valid = (state_reg == S_OUT);
  assign res_data  = res_valid ? res_word[j_reg] : 32'd0;
  assign done      = done_reg;
  assign sa_en     = sa_en_reg;
  assign sa_in     = sa_in_reg;
  assign sa_w      = w_reg;

`ifdef SYSA_SEQ_PERF_EN
  logic [15:0] perf_reg;
  // The start cycle is counted as the first cycle of the job.
  always_ff @(posedge clk) begin
    if (rst) perf_reg <= '0;
    else if (!busy && start && !abort) perf_reg <= 16'd1;
    else if (busy && perf_reg != 16'hFFFF) perf_reg <= perf_reg + 16'd1;
  end
  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_sysa_seq.sv
// Directed bench for sysa_seq: table of job scenarios plus hand sequences for reset, abort and protocol corners.
// A stub array drives out_k = {k, step} so captured words are known constants.
module tb_sysa_seq;

  logic        clk, rst, start, abort, busy, done;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_data;
  logic        sa_en;
  logic [71:0] sa_w;
  logic [23:0] sa_in;
  logic [15:0] sa_out1, sa_out2, sa_out3;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [15:0] perf_cycles;

  sysa_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .sa_en(sa_en), .sa_w(sa_w), .sa_in(sa_in),
    .sa_out1(sa_out1), .sa_out2(sa_out2), .sa_out3(sa_out3),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .perf_cycles(perf_cycles)
  );

`ifdef SYSA_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub array: step counter advances on each sa_en cycle.
  logic [7:0] stub_s;
  always @(posedge clk) begin
    if (rst || (start && !busy)) stub_s <= 8'd0;
    else if (sa_en) stub_s <= stub_s + 8'd1;
  end
  assign sa_out1 = {8'd1, stub_s};
  assign sa_out2 = {8'd2, stub_s};
  assign sa_out3 = {8'd3, stub_s};

  logic [23:0] en_log [$];
  always @(negedge clk) if (sa_en === 1'b1) en_log.push_back(sa_in);

  int n_chk = 0;
  int n_pass = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) chk({name, "_ready_timeout"}, 160'(cfg_ready), 160'(1));
  endtask

  task automatic start_job();
    en_log.delete();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic load_weights(input logic [95:0] wts, input bit restart, output bit no_en);
    no_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready("wgt");
      if (sa_en !== 1'b0) no_en = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = wts[i*32 +: 32];
      start     = restart && (i == 1);
      tick();
      start     = 1'b0;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic load_rows(input logic [71:0] rows, input int gap);
    for (int i = 0; i < 3; i++) begin
      wait_ready("row");
      cfg_valid = 1'b1;
      cfg_data  = {8'hA5, rows[i*24 +: 24]};
      tick();
      cfg_valid = 1'b0;
      if (i < 2) repeat (gap) tick();
    end
  endtask

  task automatic collect(input int stall_len, input logic [31:0] held_exp,
                         output logic [159:0] got, output int lat, output int n_got);
    int stalled = 0;
    int iter = 0;
    got = '0;
    n_got = 0;
    while (n_got < 5 && iter < 200) begin
      if (n_got == 2 && stalled < stall_len && res_valid === 1'b1) begin
        res_ready = 1'b0;
        chk($sformatf("held_word2_c%0d", stalled), 160'(res_data), 160'(held_exp));
        stalled++;
      end else begin
        res_ready = 1'b1;
        if (res_valid === 1'b1) begin
          got[n_got*32 +: 32] = res_data;
          n_got++;
        end
      end
      tick();
      iter++;
    end
    lat = cyc - t0;
  endtask

  typedef struct {
    logic [95:0]  wts;
    logic [71:0]  exp_w;
    logic [71:0]  rows;
    int           x_gap;
    int           stall_len;
    bit           restart;
    logic [119:0] exp_in;
    logic [159:0] exp_res;
    int           exp_lat;
  } scn_t;

  scn_t tbl [4];
  localparam logic [159:0] STUB_RES =
    {32'h0000_0305, 32'h0304_0303, 32'h0204_0203, 32'h0202_0103, 32'h0102_0101};

  task automatic run_scn(input int idx);
    scn_t v;
    bit no_en;
    logic [159:0] got;
    logic [119:0] seq;
    int lat, n_got;
    v = tbl[idx];
    start_job();
    load_weights(v.wts, v.restart, no_en);
    chk($sformatf("s%0d_sa_w", idx), 160'(sa_w), 160'(v.exp_w));
    chk($sformatf("s%0d_no_en_in_load_w", idx), 160'(no_en), 160'(1));
    load_rows(v.rows, v.x_gap);
    collect(v.stall_len, v.exp_res[64 +: 32], got, lat, n_got);
    chk($sformatf("s%0d_words_taken", idx), 160'(n_got), 160'(5));
    chk($sformatf("s%0d_results", idx), got, v.exp_res);
    chk($sformatf("s%0d_done", idx), 160'(done), 160'(1));
    chk($sformatf("s%0d_latency", idx), 160'(lat), 160'(v.exp_lat));
    chk($sformatf("s%0d_perf", idx), 160'(perf_cycles), PERF ? 160'(v.exp_lat) : 160'(0));
    seq = '0;
    for (int i = 0; i < 5 && i < en_log.size(); i++) seq[i*24 +: 24] = en_log[i];
    chk($sformatf("s%0d_sa_en_count", idx), 160'(en_log.size()), 160'(5));
    chk($sformatf("s%0d_sa_in_seq", idx), 160'(seq), 160'(v.exp_in));
    $display("scn %0d: res %h lat %0d perf %0d", idx, got, lat, perf_cycles);
    tick();
    chk($sformatf("s%0d_done_pulse", idx), 160'({done, busy}), 160'(0));
  endtask

  initial begin
    logic [159:0] got;
    bit no_en;
    int lat, n_got;

    tbl[0] = '{96'hFFFFFF09_08070605_04030201, 72'h090807060504030201,
               72'h000003_000002_000001, 0, 0, 1'b0,
               120'h000000_000000_000003_000002_000001, STUB_RES, 15};
    tbl[1] = '{96'hFFFFFF09_08070605_04030201, 72'h090807060504030201,
               72'h000003_000002_000001, 2, 0, 1'b0,
               120'h000000_000000_000003_000002_000001, STUB_RES, 19};
    tbl[2] = '{96'hFFFFFF09_08070605_04030201, 72'h090807060504030201,
               72'h000003_000002_000001, 0, 3, 1'b0,
               120'h000000_000000_000003_000002_000001, STUB_RES, 18};
    tbl[3] = '{96'h000000A5_01234567_DEADBEEF, 72'hA501234567DEADBEEF,
               72'h123456_00FF00_FEDCBA, 0, 0, 1'b1,
               120'h000000_000000_123456_00FF00_FEDCBA, STUB_RES, 15};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", 160'({busy, done, cfg_ready, sa_en, res_valid, res_data, perf_cycles}), 160'(0));
    chk("reset_sa_w_sa_in", 160'({sa_w, sa_in}), 160'(0));

    for (int i = 0; i < 4; i++) run_scn(i);

    // Abort in RUN with s=4, then an identical job must reproduce the results.
    start_job();
    load_weights(tbl[0].wts, 1'b0, no_en);
    load_rows(tbl[0].rows, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 160'({busy, done, sa_en, res_valid, cfg_ready}), 160'(0));
    chk("abort_en_count", 160'(en_log.size()), 160'(4));
    tick();
    chk("abort_no_done", 160'({busy, done}), 160'(0));
    $display("abort: en_log %0d busy %0d", en_log.size(), busy);
    run_scn(0);

    // start together with abort in IDLE is dropped.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 160'({busy, cfg_ready}), 160'(0));
    tick();
    chk("start_abort_idle2", 160'(busy), 160'(0));

    // Reset asserted for two cycles in the middle of LOAD_X.
    start_job();
    load_weights(tbl[3].wts, 1'b0, no_en);
    wait_ready("rst_row");
    cfg_valid = 1'b1; cfg_data = 32'h0000_0001;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("midjob_reset", 160'({busy, cfg_ready, sa_en, res_valid, done, perf_cycles}), 160'(0));
    chk("midjob_reset_sa_w", 160'(sa_w), 160'(0));
    rst = 1'b0; cfg_valid = 1'b0;
    tick();
    chk("after_reset_idle", 160'({busy, cfg_ready}), 160'(0));
    $display("reset: busy %0d sa_w %h", busy, sa_w);
    run_scn(0);

`ifdef SYSA_SEQ_PERF_EN
    // Holding res_ready low drives the job cycle counter into saturation.
    start_job();
    load_weights(tbl[0].wts, 1'b0, no_en);
    load_rows(tbl[0].rows, 0);
    res_ready = 1'b0;
    repeat (70000) tick();
    chk("perf_saturated", 160'(perf_cycles), 160'(16'hFFFF));
    chk("long_stall_word0", 160'({res_valid, res_data}), 160'({1'b1, 32'h0102_0101}));
    collect(0, 32'h0, got, lat, n_got);
    chk("sat_results", got, STUB_RES);
    chk("sat_done_perf", 160'({done, perf_cycles}), 160'({1'b1, 16'hFFFF}));
    $display("perf sat: perf %h res %h", perf_cycles, got);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
